// File: rtl/fifo_rd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_pkg
//  Description : Shared types and constants for the async-FIFO read-side
//                stream adapter (state encoding, buffer depth, count width).
//  Revision    : 1.0  initial release
// ============================================================================
package fifo_rd_pkg;

  // Adapter operating mode: normal streaming or discarding words
  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Output buffer depth and the width of its occupancy count (0..2)
  localparam int BUF_DEPTH = 2;
  localparam int CNT_W     = 2;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage
`default_nettype wire

// File: rtl/fifo_rd_stream_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_stream_if
//  Description : Bundles the FIFO read port and the valid/ready output
//                stream. The master side is the adapter; the slave side is
//                the surrounding FIFO plus stream sink.
//  Revision    : 1.0  initial release
// ============================================================================
interface fifo_rd_stream_if #(
  parameter int DSIZE = 8
);

  // FIFO zero-latency read port
  logic             fifo_rempty;
  logic [DSIZE-1:0] fifo_rdata;
  logic             fifo_rreq;

  // Output stream
  logic             m_valid;
  logic             m_ready;
  logic [DSIZE-1:0] m_data;

  modport master (
    input  fifo_rempty, fifo_rdata, m_ready,
    output fifo_rreq, m_valid, m_data
  );

  modport slave (
    output fifo_rempty, fifo_rdata, m_ready,
    input  fifo_rreq, m_valid, m_data
  );

endinterface
`default_nettype wire

// File: rtl/rd_skid_buf2.sv
`default_nettype none
// ============================================================================
//  Module      : rd_skid_buf2
//  Description : Two-entry in-order buffer with push, pop and clear. Clear
//                wins over any push/pop in the same cycle. The caller never
//                pushes when full nor pops when empty.
//  Revision    : 1.0  initial release
// ============================================================================
module rd_skid_buf2
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             push_i,
  input  wire logic [DSIZE-1:0] din_i,
  input  wire logic             pop_i,
  input  wire logic             clear_i,
  output logic      [CNT_W-1:0] count_o,
  output logic      [DSIZE-1:0] head_o
);

  logic [DSIZE-1:0] mem_q [BUF_DEPTH];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  cnt_t             count_q, count_d;

  // Next pointers and occupancy; clear empties the buffer and realigns pointers
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ~wr_ptr_q;
      if (pop_i)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + cnt_t'(push_i) - cnt_t'(pop_i);
    end
  end

  // Storage and pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push_i && !clear_i) mem_q[wr_ptr_q] <= din_i;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_stream
//  Description : Read-side adapter for the async FIFO. Pops words into a
//                2-entry buffer and presents them as a valid/ready stream.
//                A flush discards buffered words and drains the FIFO.
//                Debug counters track handshakes (wrapping) and discarded
//                words (saturating).
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int CW    = 16
) (
  input  wire logic          rclk,
  input  wire logic          rrst,
  fifo_rd_stream_if.master   bus,
  input  wire logic          flush,
  output logic               busy,
  output logic [CW-1:0]      xfer_count,
  output logic [CW-1:0]      drop_count
);

  state_t           state_q, state_d;
  logic [CW-1:0]    xfer_q, xfer_d;
  logic [CW-1:0]    drop_q, drop_d;
  logic [CW:0]      w_drop_sum;
  cnt_t             w_count;
  cnt_t             w_drop_inc;
  logic [DSIZE-1:0] w_head;
  logic             w_run;
  logic             w_flush_run;
  logic             w_rreq;
  logic             w_push;
  logic             w_hs;

  assign w_run       = (state_q == RUN);
  assign w_flush_run = w_run && flush;
  assign w_hs        = bus.m_valid && bus.m_ready;
  assign w_push      = w_run && w_rreq;

  // Pop request from registered state, empty flag and flush only; the sink's
  // ready is deliberately kept out of this path
  always_comb begin
    w_rreq = 1'b0;
    if (!rrst) begin
      if (w_run) w_rreq = !bus.fifo_rempty && (w_count < cnt_t'(BUF_DEPTH)) && !flush;
      else       w_rreq = !bus.fifo_rempty;
    end
  end

  // Mode transitions; a flush seen while already draining has no effect
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (flush)            state_d = DRAIN;
      DRAIN:   if (bus.fifo_rempty)  state_d = RUN;
      default:                       state_d = RUN;
    endcase
  end

  // Counter updates: a flush discards whatever the same-cycle handshake
  // leaves behind; in DRAIN every popped word is a discard
  always_comb begin
    w_drop_inc = '0;
    if (w_flush_run)            w_drop_inc = w_count - cnt_t'(w_hs);
    else if (!w_run && w_rreq)  w_drop_inc = cnt_t'(1);
    xfer_d     = xfer_q + CW'(w_hs);
    w_drop_sum = {1'b0, drop_q} + (CW+1)'(w_drop_inc);
    drop_d     = w_drop_sum[CW] ? {CW{1'b1}} : w_drop_sum[CW-1:0];
  end

  // State and counter registers
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q <= RUN;
      xfer_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      xfer_q  <= xfer_d;
      drop_q  <= drop_d;
    end
  end

  rd_skid_buf2 #(
    .DSIZE (DSIZE)
  ) u_buf (
    .clk     (rclk),
    .rst     (rrst),
    .push_i  (w_push),
    .din_i   (bus.fifo_rdata),
    .pop_i   (w_hs),
    .clear_i (w_flush_run),
    .count_o (w_count),
    .head_o  (w_head)
  );

  assign bus.fifo_rreq = w_rreq;
  assign bus.m_valid   = (w_count != '0) && w_run;
  assign bus.m_data    = w_head;
  assign busy          = (state_q == DRAIN);
  assign xfer_count    = xfer_q;
  assign drop_count    = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_rd_stream
//  Description : Self-checking bench for fifo_rd_stream. A queue models the
//                async FIFO read port (registered empty flag); a per-cycle
//                vector table covers streaming and back-pressure, followed
//                by hand sequences for flush, drain, reset and counter limits.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_rd_stream;

  localparam int DSIZE = 8;
  localparam int CW    = 4;

  typedef struct {
    logic       m_ready;
    logic       flush;
    int         npush;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_rreq;
    logic       exp_busy;
  } vec_t;

  logic          clk = 1'b0;
  logic          rrst;
  logic          flush;
  logic          busy;
  logic [CW-1:0] xfer_count;
  logic [CW-1:0] drop_count;

  fifo_rd_stream_if #(.DSIZE(DSIZE)) bus ();

  fifo_rd_stream #(.DSIZE(DSIZE), .CW(CW)) dut (
    .rclk       (clk),
    .rrst       (rrst),
    .bus        (bus),
    .flush      (flush),
    .busy       (busy),
    .xfer_count (xfer_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  // FIFO model state and observation records
  logic [7:0] q[$];
  logic [7:0] got[$];
  logic [7:0] src[$];
  vec_t       tbl[$];
  logic       rempty_r = 1'b1;
  logic [7:0] rdata_r  = 8'h00;
  int         n_take   = 0;
  int         rreq_rst = 0;
  int         n_vec    = 0;
  int         n_err    = 0;

  assign bus.fifo_rempty = rempty_r;
  assign bus.fifo_rdata  = rdata_r;

  // FIFO model: pop on request, empty flag and head registered at the edge;
  // also records every stream handshake
  always @(posedge clk) begin
    if (rrst && bus.fifo_rreq) rreq_rst++;
    if (bus.fifo_rreq && !rempty_r) begin
      void'(q.pop_front());
      n_take++;
    end
    if (bus.m_valid && bus.m_ready) got.push_back(bus.m_data);
    rempty_r <= (q.size() == 0);
    rdata_r  <= (q.size() != 0) ? q[0] : 8'h00;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic r, input logic f, input int np,
                              input logic ev, input logic [7:0] ed,
                              input logic er, input logic eb);
    vec_t v;
    v.m_ready = r; v.flush = f; v.npush = np;
    v.exp_valid = ev; v.exp_data = ed; v.exp_rreq = er; v.exp_busy = eb;
    tbl.push_back(v);
  endfunction

  // Waits (at negedge) until DRAIN ends; reports whether m_valid ever rose
  task automatic drain_wait(input string name, input int lim, output bit mv_seen);
    int k;
    k = 0;
    mv_seen = 1'b0;
    @(negedge clk);
    while (busy && k < lim) begin
      if (bus.m_valid) mv_seen = 1'b1;
      tick();
      @(negedge clk);
      k++;
    end
    chk(name, {31'd0, busy}, 32'd0);
    tick();
  endtask

  task automatic wait_got(input string name, input int n, input int lim);
    int k;
    k = 0;
    while (got.size() < n && k < lim) begin
      tick();
      k++;
    end
    chk(name, (got.size() >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    logic [10:0] act, exp;
    bit          mv;
    int          take0, ngot, bad;

    rrst = 1'b1; flush = 1'b0; bus.m_ready = 1'b1;
    q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33);
    src = '{8'h11, 8'h22, 8'h33, 8'h44};

    // Cycle table: streaming of 3 words, then 4 words under back-pressure
    add(1,0,0, 0,8'h00,1,0);
    add(1,0,0, 1,8'h11,1,0);
    add(1,0,0, 1,8'h22,1,0);
    add(1,0,0, 1,8'h33,0,0);
    add(0,0,4, 0,8'h00,0,0);
    add(0,0,0, 0,8'h00,1,0);
    add(0,0,0, 1,8'h11,1,0);
    for (int i = 0; i < 10; i++) add(0,0,0, 1,8'h11,0,0);
    add(1,0,0, 1,8'h11,0,0);
    add(1,0,0, 1,8'h22,1,0);
    add(1,0,0, 1,8'h33,1,0);
    add(1,0,0, 1,8'h44,0,0);
    add(1,0,0, 0,8'h00,0,0);

    // Reset state with a non-empty FIFO: no pop may be requested
    repeat (3) tick();
    @(negedge clk);
    chk("reset_rreq",  {31'd0, bus.fifo_rreq}, 32'd0);
    chk("reset_valid", {31'd0, bus.m_valid},   32'd0);
    chk("reset_data",  {24'd0, bus.m_data},    32'd0);
    chk("reset_busy",  {31'd0, busy},          32'd0);
    chk("reset_cnts",  {24'd0, xfer_count, drop_count}, 32'd0);
    @(posedge clk); #1;
    rrst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      bus.m_ready = tbl[i].m_ready;
      flush       = tbl[i].flush;
      for (int k = 0; k < tbl[i].npush; k++) q.push_back(src.pop_front());
      @(negedge clk);
      act = {bus.m_valid, bus.m_valid ? bus.m_data : 8'h00, bus.fifo_rreq, busy};
      exp = {tbl[i].exp_valid, tbl[i].exp_valid ? tbl[i].exp_data : 8'h00,
             tbl[i].exp_rreq, tbl[i].exp_busy};
      chk($sformatf("vec%0d", i), {21'd0, act}, {21'd0, exp});
      tick();
    end
    chk("t12_xfer", {28'd0, xfer_count}, 32'd7);
    chk("t12_takes", n_take, 32'd7);

    // Flush with 2 buffered and 5 queued, sink stalled
    bus.m_ready = 1'b0;
    for (int i = 0; i < 7; i++) q.push_back(8'h51 + 8'(i));
    repeat (4) tick();
    flush = 1'b1;
    @(negedge clk);
    chk("t3_flush_rreq", {31'd0, bus.fifo_rreq}, 32'd0);
    ngot = got.size();
    tick();
    flush = 1'b0;
    take0 = n_take;
    @(negedge clk);
    chk("t3_busy", {31'd0, busy}, 32'd1);
    drain_wait("t3_drain_end", 20, mv);
    chk("t3_valid_low", {31'd0, mv}, 32'd0);
    chk("t3_pops", n_take - take0, 32'd5);
    chk("t3_drop", {28'd0, drop_count}, 32'd7);
    chk("t3_no_out", got.size(), ngot);

    // Flush coinciding with a handshake at count=2
    for (int i = 0; i < 2; i++) q.push_back(8'h61 + 8'(i));
    repeat (4) tick();
    bus.m_ready = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk("t4_rreq", {31'd0, bus.fifo_rreq}, 32'd0);
    tick();
    flush = 1'b0;
    bus.m_ready = 1'b0;
    @(negedge clk);
    chk("t4_xfer", {28'd0, xfer_count}, 32'd8);
    chk("t4_drop", {28'd0, drop_count}, 32'd8);
    chk("t4_word", {24'd0, got[got.size()-1]}, 32'h61);
    drain_wait("t4_drain_end", 10, mv);

    // Second flush during DRAIN is ignored; streaming resumes afterwards
    for (int i = 0; i < 3; i++) q.push_back(8'h71 + 8'(i));
    repeat (4) tick();
    flush = 1'b1;
    tick();
    @(negedge clk);
    chk("t5_busy", {31'd0, busy}, 32'd1);
    tick();
    flush = 1'b0;
    drain_wait("t5_drain_end", 10, mv);
    chk("t5_drop", {28'd0, drop_count}, 32'd11);
    ngot = got.size();
    q.push_back(8'hA5);
    bus.m_ready = 1'b1;
    wait_got("t5_deliver", ngot + 1, 10);
    chk("t5_word", {24'd0, got[got.size()-1]}, 32'hA5);
    chk("t5_xfer", {28'd0, xfer_count}, 32'd9);

    // Reset mid-operation with two words buffered: they are lost, uncounted
    bus.m_ready = 1'b0;
    for (int i = 0; i < 3; i++) q.push_back(8'h91 + 8'(i));
    repeat (4) tick();
    rrst = 1'b1;
    q.delete();
    tick();
    @(negedge clk);
    chk("rst_mid_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("rst_mid_cnts", {24'd0, xfer_count, drop_count}, 32'd0);
    tick();
    rrst = 1'b0;
    ngot = got.size();
    bus.m_ready = 1'b1;
    repeat (4) tick();
    chk("rst_mid_lost", got.size(), ngot);

    // 17 handshakes wrap a 4-bit transfer counter to 1
    for (int i = 0; i < 17; i++) q.push_back(8'h80 + 8'(i));
    wait_got("t6_deliver", ngot + 17, 60);
    @(negedge clk);
    chk("t6_xfer", {28'd0, xfer_count}, 32'd1);
    bad = 0;
    for (int i = 0; i < 17; i++)
      if (ngot + i >= got.size() || got[ngot + i] !== 8'h80 + 8'(i)) bad++;
    chk("t6_order", bad, 32'd0);
    tick();

    // 20 discards saturate a 4-bit drop counter at 15
    bus.m_ready = 1'b0;
    take0 = n_take;
    for (int i = 0; i < 20; i++) q.push_back(8'hC0 + 8'(i));
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drain_wait("t6_drain_end", 40, mv);
    chk("t6_drop_sat", {28'd0, drop_count}, 32'd15);
    chk("t6_pops", n_take - take0, 32'd20);

    chk("rreq_in_reset", rreq_rst, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
